// File: rtl/action_selector.sv
// Epsilon-greedy action selector: each accepted Q-vector either takes an
// LFSR-random action or a signed argmax scanned one entry per cycle.
module action_selector #(
    parameter int          Q_W   = 32,
    parameter int          N_ACT = 8,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 q_valid,
    output logic                 q_ready,
    input  logic [N_ACT*Q_W-1:0] q_vec,
    input  logic [7:0]           epsilon,
    output logic [2:0]           action,
    output logic [Q_W-1:0]       q_sel,
    output logic                 explored,
    output logic                 action_valid,
    input  logic                 action_ready
);

    localparam int A_W = 3;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    localparam logic [A_W-1:0] LAST_IDX = A_W'(N_ACT - 1);

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic signed [Q_W-1:0] entry(input logic [N_ACT*Q_W-1:0] v,
                                                   input logic [A_W-1:0]       i);
        return v[int'(i)*Q_W +: Q_W];
    endfunction

    logic [1:0]              state_q,    state_d;
    logic [15:0]             lfsr_q,     lfsr_d;
    logic [A_W-1:0]          idx_q,      idx_d;
    logic [A_W-1:0]          best_idx_q, best_idx_d;
    logic signed [Q_W-1:0]   best_q_q,   best_q_d;
    logic [N_ACT*Q_W-1:0]    vec_q,      vec_d;
    logic [A_W-1:0]          action_q,   action_d;
    logic signed [Q_W-1:0]   q_sel_q,    q_sel_d;
    logic                    explored_q, explored_d;

    logic                    accept;
    logic                    explore;
    logic signed [Q_W-1:0]   cand;
    logic [A_W-1:0]          win_idx;
    logic signed [Q_W-1:0]   win_q;

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_next(lfsr_q);
        idx_d      = idx_q;
        best_idx_d = best_idx_q;
        best_q_d   = best_q_q;
        vec_d      = vec_q;
        action_d   = action_q;
        q_sel_d    = q_sel_q;
        explored_d = explored_q;

        accept  = q_valid && (state_q == S_IDLE);
        // The decision uses the LFSR value seen in the accept cycle, before it advances.
        explore = (epsilon == 8'hFF) || (lfsr_q[7:0] < epsilon);

        cand    = entry(vec_q, idx_q);
        win_idx = best_idx_q;
        win_q   = best_q_q;
        // Strictly greater only, so equal values keep the lowest index.
        if (cand > best_q_q) begin
            win_idx = idx_q;
            win_q   = cand;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    vec_d = q_vec;
                    if (explore) begin
                        action_d   = lfsr_q[10:8];
                        q_sel_d    = entry(q_vec, lfsr_q[10:8]);
                        explored_d = 1'b1;
                        state_d    = S_OUT;
                    end else begin
                        best_idx_d = '0;
                        best_q_d   = entry(q_vec, '0);
                        idx_d      = A_W'(1);
                        state_d    = S_SCAN;
                    end
                end
            end
            S_SCAN: begin
                best_idx_d = win_idx;
                best_q_d   = win_q;
                idx_d      = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    action_d   = win_idx;
                    q_sel_d    = win_q;
                    explored_d = 1'b0;
                    idx_d      = '0;
                    state_d    = S_OUT;
                end
            end
            S_OUT: begin
                if (action_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            lfsr_q     <= SEED;
            idx_q      <= '0;
            best_idx_q <= '0;
            best_q_q   <= '0;
            vec_q      <= '0;
            action_q   <= '0;
            q_sel_q    <= '0;
            explored_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            idx_q      <= idx_d;
            best_idx_q <= best_idx_d;
            best_q_q   <= best_q_d;
            vec_q      <= vec_d;
            action_q   <= action_d;
            q_sel_q    <= q_sel_d;
            explored_q <= explored_d;
        end
    end

    assign q_ready      = (state_q == S_IDLE);
    assign action_valid = (state_q == S_OUT);
    assign action       = action_q;
    assign q_sel        = q_sel_q;
    assign explored     = explored_q;

endmodule
